// File: rtl/segway_pkg.sv
// Shared types and default thresholds for the segway rider/steer/battery logic.
package segway_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    STEER_EN = 2'd2
  } steer_state_t;

  localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
  localparam logic [11:0] WT_HYST_DEF      = 12'h040;
  localparam logic [11:0] BATT_LOW_DEF     = 12'h800;
  localparam logic [11:0] BATT_HYST_DEF    = 12'h040;

endpackage

// File: rtl/steer_en_ctrl_persist.sv
// Persistence filter: flag toggles once the opposing condition holds 2^WIDTH samples.
module persist_filter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_cond,
  input  logic clr_cond,
  output logic flag
);

  logic [WIDTH-1:0] cnt;
  logic             cand;

  // the condition that would move the flag away from its current value
  assign cand = flag ? clr_cond : set_cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (!cand) begin
      cnt <= '0;
    end else if (&cnt) begin
      cnt  <= '0;
      flag <= ~flag;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/steer_en_ctrl.sv
// Rider presence / balance FSM with stability timer, plus filtered battery-low flag.
module steer_en_ctrl
  import segway_pkg::*;
#(
  parameter bit          FAST_SIM     = 1'b0,
  parameter int          TMR_BITS     = 26,
  parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
  parameter logic [11:0] WT_HYST      = WT_HYST_DEF,
  parameter logic [11:0] BATT_LOW     = BATT_LOW_DEF,
  parameter logic [11:0] BATT_HYST    = BATT_HYST_DEF,
  parameter int          BATT_FILT    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic [11:0] batt,
  output logic        en_steer,
  output logic        rider_off,
  output logic        batt_low
);

  localparam int TW = FAST_SIM ? 15 : TMR_BITS;

  localparam logic [12:0] WT_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
  localparam logic [12:0] WT_LO = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};
  localparam logic [12:0] BATT_OK = {1'b0, BATT_LOW} + {1'b0, BATT_HYST};

  steer_state_t state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;

  logic [12:0] sum, diff, q, f;
  logic [11:0] diff_raw;
  logic        present, diff_gt_1_4, diff_gt_15_16;

  assign sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign diff_raw = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
  assign diff     = {1'b0, diff_raw};
  assign q        = sum >> 2;
  assign f        = sum - (sum >> 4);

  assign diff_gt_1_4   = diff > q;
  assign diff_gt_15_16 = diff > f;
  // higher threshold to get on than to stay on
  assign present       = (state == IDLE) ? (sum > WT_HI) : (sum > WT_LO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    case (state)
      IDLE: begin
        if (present) begin
          state_nxt = WAIT;
          tmr_nxt   = '0;
        end
      end
      WAIT: begin
        if (!present)         state_nxt = IDLE;
        else if (diff_gt_1_4) tmr_nxt   = '0;
        else if (&tmr)        state_nxt = STEER_EN;
        else                  tmr_nxt   = tmr + TW'(1);
      end
      STEER_EN: begin
        if (!present) begin
          state_nxt = IDLE;
        end else if (diff_gt_15_16) begin
          state_nxt = WAIT;
          tmr_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign en_steer  = (state == STEER_EN);
  assign rider_off = (state == IDLE);

  persist_filter #(.WIDTH(BATT_FILT)) u_batt_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_cond ({1'b0, batt} < {1'b0, BATT_LOW}),
    .clr_cond ({1'b0, batt} >= BATT_OK),
    .flag     (batt_low)
  );

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Directed self-checking bench for steer_en_ctrl (FAST_SIM timer: 32768 clk to steer).
module tb_steer_en_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] lft_ld = '0, rght_ld = '0, batt = 12'hC00;
  logic        en_steer, rider_off, batt_low;

  int compared = 0;
  int mismatched = 0;

  localparam int FULL = 32768;

  steer_en_ctrl #(.FAST_SIM(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .batt      (batt),
    .en_steer  (en_steer),
    .rider_off (rider_off),
    .batt_low  (batt_low)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ld(input logic [11:0] l, input logic [11:0] r);
    lft_ld  = l;
    rght_ld = r;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_ld(12'h300, 12'h300);
    batt = 12'h100;
    tick(3);
    compared++;
    if ({en_steer, rider_off, batt_low} !== 3'b010) begin
      mismatched++;
      $display("FAIL reset_hold: got en/off/low=%b exp 010", {en_steer, rider_off, batt_low});
    end
    set_ld(12'h000, 12'h000);
    batt = 12'hC00;
    rst_n = 1'b1;
    tick(2);
    compared++;
    if ({en_steer, rider_off, batt_low} !== 3'b010) begin
      mismatched++;
      $display("FAIL reset_release: got en/off/low=%b exp 010", {en_steer, rider_off, batt_low});
    end
  endtask

  task automatic test_steer_entry;
    set_ld(12'h180, 12'h180);
    tick(1);
    compared++;
    if ({en_steer, rider_off} !== 2'b00) begin
      mismatched++;
      $display("FAIL enter_wait: got en/off=%b exp 00", {en_steer, rider_off});
    end
    tick(FULL - 1);
    compared++;
    if (en_steer !== 1'b0) begin
      mismatched++;
      $display("FAIL timer_early: got en_steer=%b exp 0", en_steer);
    end
    tick(1);
    compared++;
    if ({en_steer, rider_off} !== 2'b10) begin
      mismatched++;
      $display("FAIL timer_full: got en/off=%b exp 10", {en_steer, rider_off});
    end
  endtask

  task automatic test_steer_imbalance;
    set_ld(12'h1C0, 12'h140);
    tick(5);
    compared++;
    if (en_steer !== 1'b1) begin
      mismatched++;
      $display("FAIL steer_mild_imbal: got en_steer=%b exp 1", en_steer);
    end
    set_ld(12'h2F0, 12'h010);
    tick(1);
    compared++;
    if ({en_steer, rider_off} !== 2'b00) begin
      mismatched++;
      $display("FAIL steer_to_wait: got en/off=%b exp 00", {en_steer, rider_off});
    end
  endtask

  task automatic test_wait_imbalance;
    set_ld(12'h180, 12'h180);
    tick(10000);
    set_ld(12'h280, 12'h080);
    tick(3);
    compared++;
    if ({en_steer, rider_off} !== 2'b00) begin
      mismatched++;
      $display("FAIL wait_imbal: got en/off=%b exp 00", {en_steer, rider_off});
    end
    set_ld(12'h180, 12'h180);
    tick(FULL - 1);
    compared++;
    if (en_steer !== 1'b0) begin
      mismatched++;
      $display("FAIL timer_restart_early: got en_steer=%b exp 0", en_steer);
    end
    tick(1);
    compared++;
    if (en_steer !== 1'b1) begin
      mismatched++;
      $display("FAIL timer_restart_full: got en_steer=%b exp 1", en_steer);
    end
  endtask

  task automatic test_hysteresis;
    set_ld(12'h0E8, 12'h0E8);
    tick(3);
    compared++;
    if ({en_steer, rider_off} !== 2'b10) begin
      mismatched++;
      $display("FAIL hyst_stay_steer: got en/off=%b exp 10", {en_steer, rider_off});
    end
    set_ld(12'h0D8, 12'h0D8);
    tick(1);
    compared++;
    if ({en_steer, rider_off} !== 2'b01) begin
      mismatched++;
      $display("FAIL hyst_drop: got en/off=%b exp 01", {en_steer, rider_off});
    end
    set_ld(12'h118, 12'h118);
    tick(3);
    compared++;
    if (rider_off !== 1'b1) begin
      mismatched++;
      $display("FAIL hyst_stay_idle: got rider_off=%b exp 1", rider_off);
    end
    set_ld(12'h128, 12'h128);
    tick(1);
    compared++;
    if ({en_steer, rider_off} !== 2'b00) begin
      mismatched++;
      $display("FAIL hyst_mount: got en/off=%b exp 00", {en_steer, rider_off});
    end
    set_ld(12'h1B0, 12'h000);
    tick(1);
    compared++;
    if ({en_steer, rider_off} !== 2'b01) begin
      mismatched++;
      $display("FAIL drop_and_imbal: got en/off=%b exp 01", {en_steer, rider_off});
    end
  endtask

  task automatic test_reset_mid_wait;
    set_ld(12'h180, 12'h180);
    tick(100);
    compared++;
    if (rider_off !== 1'b0) begin
      mismatched++;
      $display("FAIL pre_reset_wait: got rider_off=%b exp 0", rider_off);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({en_steer, rider_off} !== 2'b01) begin
      mismatched++;
      $display("FAIL async_reset: got en/off=%b exp 01", {en_steer, rider_off});
    end
    set_ld(12'h000, 12'h000);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    compared++;
    if ({en_steer, rider_off} !== 2'b01) begin
      mismatched++;
      $display("FAIL post_reset_idle: got en/off=%b exp 01", {en_steer, rider_off});
    end
  endtask

  task automatic test_batt;
    batt = 12'h7F0;
    tick(255);
    compared++;
    if (batt_low !== 1'b0) begin
      mismatched++;
      $display("FAIL batt_set_early: got batt_low=%b exp 0", batt_low);
    end
    tick(1);
    compared++;
    if (batt_low !== 1'b1) begin
      mismatched++;
      $display("FAIL batt_set: got batt_low=%b exp 1", batt_low);
    end
    batt = 12'h820;
    tick(300);
    compared++;
    if (batt_low !== 1'b1) begin
      mismatched++;
      $display("FAIL batt_hyst_band: got batt_low=%b exp 1", batt_low);
    end
    batt = 12'h840;
    tick(255);
    compared++;
    if (batt_low !== 1'b1) begin
      mismatched++;
      $display("FAIL batt_clr_early: got batt_low=%b exp 1", batt_low);
    end
    tick(1);
    compared++;
    if (batt_low !== 1'b0) begin
      mismatched++;
      $display("FAIL batt_clr: got batt_low=%b exp 0", batt_low);
    end
    batt = 12'h7F0;
    tick(100);
    batt = 12'h900;
    tick(10);
    batt = 12'h7F0;
    tick(255);
    compared++;
    if (batt_low !== 1'b0) begin
      mismatched++;
      $display("FAIL batt_glitch_restart: got batt_low=%b exp 0", batt_low);
    end
    tick(1);
    compared++;
    if (batt_low !== 1'b1) begin
      mismatched++;
      $display("FAIL batt_glitch_set: got batt_low=%b exp 1", batt_low);
    end
  endtask

  initial begin
    test_reset();
    test_steer_entry();
    test_steer_imbalance();
    test_wait_imbalance();
    test_hysteresis();
    test_reset_mid_wait();
    test_batt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
